// File: rtl/int_flag_sequencer.sv
// Interrupt sequencer for the RAT CPU.
// Synchronizes the external interrupt line and keeps the interrupt-enable (I) flag.
// It takes a pending interrupt at an instruction boundary: it saves the C/Z shadow
// flags, requests the vector, tracks the ISR, and restores the shadow flags on RETIE.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   intr            asynchronous external interrupt request (rising-edge sensitive)
//   instr_done      instruction-boundary pulse from the control unit
//   sei, cli        set / clear the I flag (honoured only in idle)
//   retie           RETIE executed (honoured only while in the ISR)
//   ack             control unit has pushed PC and loaded pc_vec
//   int_req         push-PC / load-vector request
//   pc_vec          constant ISR address
//   flg_shad_ld     load the C/Z shadow registers from the live flags
//   flg_ld_sel      flag input mux select, 1 = shadow values
//   flg_restore_ld  flag load strobe for the restore
//   i_flag, pend, in_isr  status outputs
//   drop_cnt        saturating count of edges lost while an interrupt was pending
module int_flag_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [9:0]  VECTOR      = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       intr,
  input  logic       instr_done,
  input  logic       sei,
  input  logic       cli,
  input  logic       retie,
  input  logic       ack,
  output logic       int_req,
  output logic [9:0] pc_vec,
  output logic       flg_shad_ld,
  output logic       flg_ld_sel,
  output logic       flg_restore_ld,
  output logic       i_flag,
  output logic       pend,
  output logic       in_isr,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {StIdle, StSave, StVector, StIsr, StRestore} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pend_q, pend_d;
  logic                   i_flag_q, i_flag_d;
  logic [7:0]             drop_q, drop_d;
  logic                   intr_edge;
  logic                   take_int;

  assign intr_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign take_int  = (state_q == StIdle) & pend_q & i_flag_q & instr_done;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    i_flag_d = i_flag_q;
    drop_d   = drop_q;

    unique case (state_q)
      StIdle: begin
        if (take_int) begin
          state_d  = StSave;
          i_flag_d = 1'b0;
        end else if (cli) begin
          i_flag_d = 1'b0;
        end else if (sei) begin
          i_flag_d = 1'b1;
        end
      end
      StSave:    state_d = StVector;
      StVector:  if (ack) state_d = StIsr;
      StIsr:     if (retie) state_d = StRestore;
      StRestore: begin
        state_d  = StIdle;
        i_flag_d = 1'b1;
      end
      default:   state_d = StIdle;
    endcase

    // A new edge in the same cycle as the clear keeps the interrupt pending.
    if (intr_edge) begin
      pend_d = 1'b1;
    end else if (take_int) begin
      pend_d = 1'b0;
    end

    if (intr_edge && pend_q && (drop_q != 8'd255)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pend_q   <= 1'b0;
      i_flag_q <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], intr};
      prev_q   <= sync_q[SYNC_STAGES-1];
      pend_q   <= pend_d;
      i_flag_q <= i_flag_d;
      drop_q   <= drop_d;
    end
  end

  // Outputs decode registered state only.
  assign int_req        = (state_q == StVector);
  assign flg_shad_ld    = (state_q == StSave);
  assign flg_ld_sel     = (state_q == StRestore);
  assign flg_restore_ld = (state_q == StRestore);
  assign in_isr         = (state_q == StIsr);
  assign pc_vec         = VECTOR;
  assign i_flag         = i_flag_q;
  assign pend           = pend_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_int_flag_sequencer.sv
// Directed bench for int_flag_sequencer with hand-computed expectations.
module tb_int_flag_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       intr, instr_done, sei, cli, retie, ack;
  logic       int_req, flg_shad_ld, flg_ld_sel, flg_restore_ld, i_flag, pend, in_isr;
  logic [9:0] pc_vec;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  int_flag_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .intr           (intr),
    .instr_done     (instr_done),
    .sei            (sei),
    .cli            (cli),
    .retie          (retie),
    .ack            (ack),
    .int_req        (int_req),
    .pc_vec         (pc_vec),
    .flg_shad_ld    (flg_shad_ld),
    .flg_ld_sel     (flg_ld_sel),
    .flg_restore_ld (flg_restore_ld),
    .i_flag         (i_flag),
    .pend           (pend),
    .in_isr         (in_isr),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic intr_pulse();
    intr = 1'b1;
    tick();
    intr = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; intr = 0; instr_done = 0; sei = 0; cli = 0; retie = 0; ack = 0;
    #1;
    chk("rst_int_req", int_req, 0);
    chk("rst_shad_ld", flg_shad_ld, 0);
    chk("rst_ld_sel", flg_ld_sel, 0);
    chk("rst_restore", flg_restore_ld, 0);
    chk("rst_i_flag", i_flag, 0);
    chk("rst_pend", pend, 0);
    chk("rst_in_isr", in_isr, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("pc_vec", pc_vec, 10'h3FF);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic entry sequence.
    sei = 1; tick(); sei = 0;
    chk("sei_sets", i_flag, 1);
    intr = 1; tick(); intr = 0;
    chk("pend_e1", pend, 0);
    tick();
    chk("pend_e2", pend, 0);
    tick();
    chk("pend_e3", pend, 1);
    ticks(2);
    instr_done = 1; tick(); instr_done = 0;
    chk("save_shad", flg_shad_ld, 1);
    chk("save_i_flag", i_flag, 0);
    chk("save_pend", pend, 0);
    chk("save_no_req", int_req, 0);
    tick();
    chk("vec_shad_off", flg_shad_ld, 0);
    chk("vec_req", int_req, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("vec_hold", int_req, 1);
    end
    ack = 1; tick(); ack = 0;
    chk("ack_req_off", int_req, 0);
    chk("ack_in_isr", in_isr, 1);
    tick();
    chk("isr_stay", in_isr, 1);
    retie = 1; tick(); retie = 0;
    chk("rest_sel", flg_ld_sel, 1);
    chk("rest_ld", flg_restore_ld, 1);
    chk("rest_i_flag", i_flag, 0);
    chk("rest_isr_off", in_isr, 0);
    tick();
    chk("idle_sel", flg_ld_sel, 0);
    chk("idle_ld", flg_restore_ld, 0);
    chk("idle_i_flag", i_flag, 1);

    // Masked interrupt stays pending.
    cli = 1; tick(); cli = 0;
    chk("cli_clears", i_flag, 0);
    intr_pulse(); tick();
    chk("masked_pend", pend, 1);
    for (int i = 0; i < 3; i++) begin
      instr_done = 1; tick(); instr_done = 0;
      chk("masked_no_shad", flg_shad_ld, 0);
      chk("masked_no_req", int_req, 0);
    end
    chk("masked_pend_hold", pend, 1);
    sei = 1; tick(); sei = 0;
    instr_done = 1; tick(); instr_done = 0;
    chk("unmask_shad", flg_shad_ld, 1);
    tick();
    ack = 1; tick(); ack = 0;
    chk("isr2", in_isr, 1);

    // Edge during ISR is serviced after RESTORE.
    intr_pulse(); tick();
    chk("isr_edge_pend", pend, 1);
    chk("isr_edge_in_isr", in_isr, 1);
    retie = 1; tick(); retie = 0;
    tick();
    chk("post_isr_i", i_flag, 1);
    chk("post_isr_pend", pend, 1);
    instr_done = 1; tick(); instr_done = 0;
    chk("second_save", flg_shad_ld, 1);
    tick();
    ack = 1; tick(); ack = 0;
    retie = 1; tick(); retie = 0;
    tick();
    chk("back_idle_i", i_flag, 1);

    // RETIE in idle is ignored; SEI/CLI act.
    retie = 1; cli = 1; tick(); retie = 0; cli = 0;
    chk("idle_retie_ld", flg_restore_ld, 0);
    chk("idle_retie_sel", flg_ld_sel, 0);
    chk("idle_cli", i_flag, 0);
    retie = 1; sei = 1; tick(); retie = 0; sei = 0;
    chk("idle_retie_ld2", flg_restore_ld, 0);
    chk("idle_sei", i_flag, 1);

    // Drop counter with interrupts masked.
    cli = 1; tick(); cli = 0;
    chk("drop_start", drop_cnt, 0);
    for (int i = 0; i < 11; i++) intr_pulse();
    ticks(3);
    chk("drop_10", drop_cnt, 10);
    for (int i = 0; i < 290; i++) intr_pulse();
    ticks(3);
    chk("drop_sat", drop_cnt, 255);
    chk("drop_pend", pend, 1);
    sei = 1; tick(); sei = 0;
    chk("sei_again", i_flag, 1);
    sei = 1; cli = 1; tick(); sei = 0; cli = 0;
    chk("cli_wins", i_flag, 0);

    // Asynchronous reset during VECTOR.
    sei = 1; tick(); sei = 0;
    instr_done = 1; tick(); instr_done = 0;
    tick();
    chk("pre_rst_req", int_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", int_req, 0);
    chk("arst_i_flag", i_flag, 0);
    chk("arst_pend", pend, 0);
    chk("arst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req", int_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_flag_sequencer.md
# int_flag_sequencer

Interrupt sequencer for the RAT CPU. It synchronizes the external interrupt line, keeps the interrupt-enable (I) flag, and waits for an instruction boundary to take an interrupt. On entry it drives the shadow-flag save (FLG_SHAD_LD) and the vector request; on RETIE it drives the shadow-flag restore (FLG_LD_SEL plus flag load). It sits beside the control unit and drives the controlling end of the C/Z shadow-flag register interface.

## Interface
- SYNC_STAGES, 2, synchronizer depth on INTR (legal values 2–4)
- VECTOR, 10'h3FF, ISR address driven on PC_VEC
- CLK  in  1  system clock; all state changes on the rising edge
- RST_N  in  1  asynchronous active-low reset
- INTR  in  1  external interrupt request; asynchronous, rising-edge sensitive
- INSTR_DONE  in  1  one-cycle pulse from the control unit at an instruction boundary
- SEI  in  1  one-cycle pulse: set the I flag
- CLI  in  1  one-cycle pulse: clear the I flag
- RETIE  in  1  one-cycle pulse: RETIE has executed (PC already popped)
- ACK  in  1  control unit has pushed PC and loaded PC_VEC
- INT_REQ  out  1  request to the control unit to push PC and load the vector
- PC_VEC  out  10  constant VECTOR
- FLG_SHAD_LD  out  1  load the C/Z shadow registers from the live flags
- FLG_LD_SEL  out  1  flag input mux select; 1 = shadow values
- FLG_RESTORE_LD  out  1  ORed externally into FLG_C_LD and FLG_Z_LD
- I_FLAG  out  1  interrupt enable
- PEND  out  1  interrupt pending
- IN_ISR  out  1  high while an ISR is executing
- DROP_CNT  out  8  count of interrupt edges lost while PEND was already high; saturates

## Operation
- INTR passes through SYNC_STAGES flip-flops, then one edge register. A rising edge (sync=1, prev=0) sets PEND.
- PEND clears on entry to SAVE. If an edge arrives in the same cycle as the clear, PEND stays 1 (the new edge wins).
- An edge while PEND=1 increments DROP_CNT. DROP_CNT holds at 255 when saturated.
- I_FLAG:
  - SEI sets it and CLI clears it, in IDLE only.
  - If SEI and CLI arrive together, CLI wins.
  - SEI and CLI are ignored in all other states.
  - I_FLAG clears on entry to SAVE and sets on exit from RESTORE.
- FSM states are IDLE, SAVE, VECTOR, ISR, RESTORE.
  - IDLE→SAVE when PEND & I_FLAG & INSTR_DONE in the same cycle; otherwise stay in IDLE.
  - SAVE lasts one cycle: FLG_SHAD_LD=1. The shadow registers capture C/Z at the closing edge. Next state is VECTOR.
  - VECTOR: INT_REQ=1, held until ACK=1 is sampled, then ISR. ACK is ignored outside VECTOR.
  - ISR: IN_ISR=1. RETIE moves the FSM to RESTORE. RETIE in any other state is ignored, with no flag restore.
  - RESTORE lasts one cycle: FLG_LD_SEL=1 and FLG_RESTORE_LD=1. Next state is IDLE, and I_FLAG=1 from the first IDLE cycle.
- Edges that arrive during SAVE, VECTOR, ISR or RESTORE set PEND. They are serviced after RESTORE, at the next boundary. There is no nesting.
- All outputs are decoded from registered state and have no combinational path from inputs. FLG_LD_SEL=0 in every state except RESTORE.

## Timing
- Reset values: state IDLE, all sync/edge flops 0, PEND=0, I_FLAG=0, DROP_CNT=0, INT_REQ=0, FLG_SHAD_LD=0, FLG_LD_SEL=0, FLG_RESTORE_LD=0, IN_ISR=0. PC_VEC is always VECTOR.
- INTR rising edge to PEND=1: SYNC_STAGES+1 edges (3 at default).
- INSTR_DONE edge to FLG_SHAD_LD=1: 1 cycle. INT_REQ follows 1 cycle later.
- ACK sampled high: INT_REQ=0 and IN_ISR=1 in the next cycle.
- RETIE sampled in ISR: restore pulse in the next cycle, I_FLAG=1 one cycle after that.
- Reset asserted mid-sequence (any state) returns to the reset values immediately; the shadow restore is abandoned.

## Test plan
- Reset, SEI, INTR pulse, INSTR_DONE 5 cycles later → PEND=1 at edge 3; FLG_SHAD_LD=1 for exactly 1 cycle; then INT_REQ=1; I_FLAG=0; PEND=0.
- Hold ACK low 4 cycles in VECTOR → INT_REQ stays 1 for all 4. ACK=1 → IN_ISR=1 next cycle. RETIE → FLG_LD_SEL=FLG_RESTORE_LD=1 for 1 cycle, then I_FLAG=1, state IDLE.
- I_FLAG=0 with INTR edge and INSTR_DONE pulses → no FLG_SHAD_LD or INT_REQ; PEND stays 1. SEI then INSTR_DONE → sequence starts.
- 300 INTR edges while PEND=1 and I_FLAG=0 → DROP_CNT=255. SEI and CLI in the same cycle → I_FLAG=0.
- INTR edge during ISR; RETIE; INSTR_DONE → second SAVE occurs. RETIE and SEI/CLI pulsed in IDLE → no restore, and I_FLAG follows SEI/CLI.
- RST_N low during VECTOR → INT_REQ=0, I_FLAG=0, PEND=0, DROP_CNT=0 asynchronously, without waiting for a clock edge.
